// File: rtl/hazard_seq.sv
// Pipeline hazard sequencer: stalls, flushes, memory-wait FSM, perf counters, watchdog.
// Define HAZARD_FORWARDING_EN when a forwarding unit exists (load-use stalls only).
module hazard_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_src1,
   input  logic [3:0]  id_src2,
   input  logic        id_use_src1,
   input  logic        id_two_src,
   input  logic [3:0]  ex_dest,
   input  logic        ex_wb_en,
   input  logic        ex_mem_read,
   input  logic [3:0]  mem_dest,
   input  logic        mem_wb_en,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        pc_en,
   output logic        ifid_load,
   output logic        idex_load,
   output logic        exmem_load,
   output logic        memwb_load,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        mem_timeout,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        state
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned WD_W  = 8;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [WD_W-1:0] wd_q;
   logic            m1x, m2x, m1m, m2m;
   logic            hazard;
   logic            branch_case;
   logic            hazard_case;

   // RAW match terms; register 0 is an ordinary register here
   assign m1x = id_use_src1 & ex_wb_en  & (ex_dest  == id_src1);
   assign m2x = id_two_src  & ex_wb_en  & (ex_dest  == id_src2);
   assign m1m = id_use_src1 & mem_wb_en & (mem_dest == id_src1);
   assign m2m = id_two_src  & mem_wb_en & (mem_dest == id_src2);

`ifdef HAZARD_FORWARDING_EN
   // Forwarding covers everything but a load result consumed immediately
   logic unused_cfg;
   assign hazard     = ex_mem_read & (m1x | m2x);
   assign unused_cfg = m1m | m2m;
`else
   logic unused_cfg;
   assign hazard     = m1x | m2x | m1m | m2m;
   assign unused_cfg = ex_mem_read;
`endif

   assign state = state_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next state: any busy cycle waits, the first idle cycle resumes with no dead cycle
   always_comb begin
      state_d = RUN;
      if (mem_busy) state_d = MEM_WAIT;
   end

   // Control outputs; branch beats hazard since the hazarding instruction is squashed
   always_comb begin
      pc_en       = 1'b1;
      ifid_load   = 1'b1;
      idex_load   = 1'b1;
      exmem_load  = 1'b1;
      memwb_load  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      branch_case = 1'b0;
      hazard_case = 1'b0;
      if (rst) begin
         pc_en      = 1'b0;
         ifid_load  = 1'b0;
         idex_load  = 1'b0;
         exmem_load = 1'b0;
         memwb_load = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (mem_busy || state_q == MEM_WAIT && mem_busy) begin
         pc_en      = 1'b0;
         ifid_load  = 1'b0;
         idex_load  = 1'b0;
         exmem_load = 1'b0;
         memwb_load = 1'b0;
      end else if (branch_taken) begin
         branch_case = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (hazard) begin
         hazard_case = 1'b1;
         pc_en       = 1'b0;
         ifid_load   = 1'b0;
         idex_flush  = 1'b1;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((mem_busy || hazard_case) && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (branch_case && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   // Watchdog on consecutive busy cycles; the timeout flag is sticky until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q        <= '0;
         mem_timeout <= 1'b0;
      end else if (mem_busy) begin
         if (wd_q != '1) wd_q <= wd_q + WD_W'(1);
         if (wd_q == WD_W'(254)) mem_timeout <= 1'b1;
      end else begin
         wd_q <= '0;
      end
   end

endmodule

// File: tb/tb_hazard_seq.sv
// Randomized and directed bench for hazard_seq against a cycle-level behavioural model.
module tb_hazard_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  id_src1, id_src2, ex_dest, mem_dest;
   logic        id_use_src1, id_two_src, ex_wb_en, ex_mem_read, mem_wb_en;
   logic        branch_taken, mem_busy;
   logic        pc_en, ifid_load, idex_load, exmem_load, memwb_load;
   logic        ifid_flush, idex_flush, mem_timeout, state;
   logic [15:0] stall_cnt, flush_cnt;
   logic [6:0]  ctl;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   int m_stall, m_flush, m_wd;
   bit m_state, m_to;

   always #5 clk = ~clk;

   hazard_seq dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_two_src(id_two_src),
      .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_en(pc_en), .ifid_load(ifid_load), .idex_load(idex_load),
      .exmem_load(exmem_load), .memwb_load(memwb_load),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .state(state)
   );

   assign ctl = {pc_en, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hazard();
      bit m1x, m2x, m1m, m2m;
      m1x = id_use_src1 && ex_wb_en  && (ex_dest  == id_src1);
      m2x = id_two_src  && ex_wb_en  && (ex_dest  == id_src2);
      m1m = id_use_src1 && mem_wb_en && (mem_dest == id_src1);
      m2m = id_two_src  && mem_wb_en && (mem_dest == id_src2);
`ifdef HAZARD_FORWARDING_EN
      return ex_mem_read && (m1x || m2x);
`else
      return m1x || m2x || m1m || m2m;
`endif
   endfunction

   task automatic clear_inputs();
      id_src1 = 4'd0; id_src2 = 4'd0; ex_dest = 4'd0; mem_dest = 4'd0;
      id_use_src1 = 1'b0; id_two_src = 1'b0; ex_wb_en = 1'b0;
      ex_mem_read = 1'b0; mem_wb_en = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   // Called at a falling edge with inputs applied; checks, then advances one clock
   task automatic step(input bit do_chk);
      logic [6:0] exp_ctl, mask;
      bit stall_ev, flush_ev;
      #1;
      mask = 7'h7F; stall_ev = 0; flush_ev = 0;
      if (mem_busy) begin
         exp_ctl = 7'b0000000; stall_ev = 1;
      end else if (branch_taken) begin
         exp_ctl = 7'b1111111; flush_ev = 1;
      end else if (model_hazard()) begin
         exp_ctl = 7'b0001101; mask = 7'b1101111; stall_ev = 1;
      end else begin
         exp_ctl = 7'b1111100;
      end
      if (do_chk) begin
         check("ctl", 32'(ctl & mask), 32'(exp_ctl & mask));
         check("state", 32'(state), 32'(m_state));
         check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
         check("mem_timeout", 32'(mem_timeout), 32'(m_to));
      end
      @(posedge clk);
      m_state = mem_busy;
      if (stall_ev) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (flush_ev) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      m_wd = mem_busy ? ((m_wd < 255) ? m_wd + 1 : 255) : 0;
      if (m_wd == 255) m_to = 1;
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges; effects must be visible at once
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_ctl"}, 32'(ctl), 32'(7'b0000011));
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_stall"}, 32'(stall_cnt), 32'd0);
      check({tag, "_flush"}, 32'(flush_cnt), 32'd0);
      check({tag, "_timeout"}, 32'(mem_timeout), 32'd0);
      m_stall = 0; m_flush = 0; m_wd = 0; m_state = 0; m_to = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      apply_reset("rst0");

      // Load-use hazard on EX
      ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd3; id_src1 = 4'd3; id_use_src1 = 1'b1;
      step(1);
      check("lu_stall", 32'(stall_cnt), 32'd1);
      // Same dependency without a load
      ex_mem_read = 1'b0;
      step(1);
`ifdef HAZARD_FORWARDING_EN
      check("ex_raw_stall", 32'(stall_cnt), 32'd1);
`else
      check("ex_raw_stall", 32'(stall_cnt), 32'd2);
`endif

      // RAW on the MEM-stage result via src2
      clear_inputs();
      apply_reset("rst1");
      mem_wb_en = 1'b1; mem_dest = 4'd5; id_two_src = 1'b1; id_src2 = 4'd5;
      step(1);
`ifdef HAZARD_FORWARDING_EN
      check("mem_raw_stall", 32'(stall_cnt), 32'd0);
`else
      check("mem_raw_stall", 32'(stall_cnt), 32'd1);
`endif

      // Branch coinciding with a load-use hazard
      clear_inputs();
      apply_reset("rst2");
      ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd0; id_src1 = 4'd0; id_use_src1 = 1'b1;
      branch_taken = 1'b1;
      step(1);
      check("br_haz_flush", 32'(flush_cnt), 32'd1);
      check("br_haz_stall", 32'(stall_cnt), 32'd0);

      // Branch held through a four-cycle memory wait
      clear_inputs();
      apply_reset("rst3");
      branch_taken = 1'b1; mem_busy = 1'b1;
      repeat (4) step(1);
      mem_busy = 1'b0;
      step(1);
      branch_taken = 1'b0;
      step(1);
      check("wait_stall", 32'(stall_cnt), 32'd4);
      check("wait_flush", 32'(flush_cnt), 32'd1);

      // Watchdog
      clear_inputs();
      apply_reset("rst4");
      mem_busy = 1'b1;
      repeat (254) step(1);
      check("to_254", 32'(mem_timeout), 32'd0);
      step(1);
      check("to_255", 32'(mem_timeout), 32'd1);
      repeat (45) step(1);
      mem_busy = 1'b0;
      repeat (2) step(1);
      check("to_sticky", 32'(mem_timeout), 32'd1);
      apply_reset("rst5");

      // Randomized traffic over a small register range to provoke matches
      repeat (3000) begin
         id_src1      = 4'($urandom_range(0, 3));
         id_src2      = 4'($urandom_range(0, 3));
         ex_dest      = 4'($urandom_range(0, 3));
         mem_dest     = 4'($urandom_range(0, 3));
         id_use_src1  = 1'($urandom_range(0, 1));
         id_two_src   = 1'($urandom_range(0, 1));
         ex_wb_en     = 1'($urandom_range(0, 1));
         ex_mem_read  = 1'($urandom_range(0, 1));
         mem_wb_en    = 1'($urandom_range(0, 1));
         branch_taken = ($urandom_range(0, 5) == 0);
         mem_busy     = ($urandom_range(0, 6) == 0);
         step(1);
      end

      // Saturation of the stall counter under a held load-use hazard
      clear_inputs();
      apply_reset("rst6");
      ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd1; id_src1 = 4'd1; id_use_src1 = 1'b1;
      repeat (65540) step(0);
      check("stall_sat", 32'(stall_cnt), 32'hFFFF);
      step(1);
      check("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);

      // Reset in the middle of a memory wait
      mem_busy = 1'b1;
      step(1);
      check("in_wait", 32'(state), 32'd1);
      apply_reset("rst7");
      clear_inputs();
      step(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_seq.md
HAZARD_SEQ -- requirements
Module: hazard_seq

Interface
REQ-001 The module SHALL have an input `clk`, 1 bit: the pipeline clock; all state changes on its rising edge.
REQ-002 The module SHALL have an input `rst`, 1 bit: reset, asynchronous, active-high.
REQ-003 The module SHALL have inputs `id_src1` and `id_src2`, 4 bits each: the source register numbers of the instruction in ID.
REQ-004 The module SHALL have an input `id_use_src1`, 1 bit: the ID instruction reads `id_src1`.
REQ-005 The module SHALL have an input `id_two_src`, 1 bit: the ID instruction also reads `id_src2`.
REQ-006 The module SHALL have inputs `ex_dest` (4 bits), `ex_wb_en` (1 bit) and `ex_mem_read` (1 bit): the destination, write-back enable and load flag of the instruction in EX.
REQ-007 The module SHALL have inputs `mem_dest` (4 bits) and `mem_wb_en` (1 bit): the destination and write-back enable of the instruction in MEM.
REQ-008 The module SHALL have an input `branch_taken`, 1 bit: a branch resolved taken in EX.
REQ-009 The module SHALL have an input `mem_busy`, 1 bit: the data memory has not completed the current access.
REQ-010 The module SHALL have outputs `pc_en`, `ifid_load`, `idex_load`, `exmem_load` and `memwb_load`, 1 bit each: load enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-011 The module SHALL have outputs `ifid_flush` and `idex_flush`, 1 bit each: synchronous clears that insert a bubble.
REQ-012 The module SHALL have an output `mem_timeout`, 1 bit: a sticky watchdog flag.
REQ-013 The module SHALL have outputs `stall_cnt` and `flush_cnt`, 16 bits each: saturating performance counters.
REQ-014 The module SHALL have an output `state`, 1 bit: 0 = RUN, 1 = MEM_WAIT.

Function
REQ-015 Match terms SHALL be defined as: `m1x` = `id_use_src1` & `ex_wb_en` & (`ex_dest` == `id_src1`); `m2x` = `id_two_src` & `ex_wb_en` & (`ex_dest` == `id_src2`); `m1m` and `m2m` are formed the same way from `mem_dest` and `mem_wb_en`.
REQ-016 `hazard` SHALL be computed combinationally as selected by REQ-039 and REQ-040.
REQ-017 Control outputs SHALL be combinational from `state` and the inputs; the counters, `state` and `mem_timeout` SHALL be registered.
REQ-018 Priority SHALL be `mem_busy` > `branch_taken` > `hazard` > normal.
REQ-019 When `mem_busy` = 1 (either state), the module SHALL drive all five load enables = 0 and both flushes = 0, and the next state SHALL be MEM_WAIT.
REQ-020 When `mem_busy` = 0, the next state SHALL be RUN.
REQ-021 The MEM_WAIT to RUN transition SHALL add no dead cycle: outputs in the `mem_busy` = 0 cycle follow REQ-022 to REQ-024.
REQ-022 Branch case (`branch_taken` = 1): `pc_en` = 1 (target loaded); `ifid_flush` = 1; `idex_flush` = 1; all loads = 1.
REQ-023 A branch coinciding with a hazard SHALL take the branch case, because the hazard instruction is discarded.
REQ-024 Hazard case (`hazard` = 1, no branch): `pc_en` = 0; `ifid_load` = 0; `idex_flush` = 1 (bubble); `exmem_load` = 1; `memwb_load` = 1.
REQ-025 Normal case: all loads = 1 and all flushes = 0.
REQ-026 A flush SHALL dominate the load of the same register.
REQ-027 A `branch_taken` that is held through MEM_WAIT SHALL be acted on in the first cycle after `mem_busy` falls, exactly once.
REQ-028 `stall_cnt` SHALL increment by 1 in each cycle with `mem_busy` = 1 or a hazard case.
REQ-029 `flush_cnt` SHALL increment by 1 in each branch-case cycle.
REQ-030 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-031 A watchdog SHALL count consecutive cycles with `mem_busy` = 1 (8 bits) and clear when `mem_busy` = 0.
REQ-032 When the watchdog reaches 255 the module SHALL set `mem_timeout` = 1; the watchdog SHALL hold at 255.
REQ-033 `mem_timeout` SHALL stay set until reset.
REQ-034 Register 0 SHALL receive no special treatment (no r0 exemption).

Reset
REQ-035 Asserting `rst` SHALL immediately force `state` = RUN, `stall_cnt` = 0, `flush_cnt` = 0, watchdog = 0 and `mem_timeout` = 0.
REQ-036 While `rst` = 1, the outputs SHALL be `pc_en` = 0, all loads = 0 and `ifid_flush` = `idex_flush` = 1.
REQ-037 A reset asserted in MEM_WAIT SHALL discard the wait; after release the module SHALL evaluate inputs in RUN.
REQ-038 The first rising clock edge after `rst` deasserts SHALL update state normally.

Configuration
REQ-039 With `HAZARD_FORWARDING_EN` defined (forwarding unit present), `hazard` SHALL equal `ex_mem_read` & (`m1x` | `m2x`): load-use only, one-cycle stall.
REQ-040 Without `HAZARD_FORWARDING_EN`, `hazard` SHALL equal `m1x` | `m2x` | `m1m` | `m2m`: any RAW dependency on EX or MEM stalls until it retires.

Verification
REQ-041 Load-use: `ex_mem_read` = 1, `ex_dest` = 3, `id_src1` = 3, `id_use_src1` = 1 -> one cycle with `pc_en` = 0, `ifid_load` = 0, `idex_flush` = 1; `stall_cnt` = 1. Same stimulus with `ex_mem_read` = 0 -> stall only when the macro is undefined.
REQ-042 MEM RAW: `mem_wb_en` = 1, `mem_dest` = 5, `id_two_src` = 1, `id_src2` = 5 -> stall when the macro is undefined; no stall when it is defined.
REQ-043 Branch combined with a hazard -> `ifid_flush` = `idex_flush` = 1, `pc_en` = 1; `flush_cnt` = 1; `stall_cnt` unchanged.
REQ-044 `mem_busy` high for 4 cycles with `branch_taken` held -> 4 cycles with all loads = 0 and `state` = 1, then exactly one branch cycle; `stall_cnt` = 4.
REQ-045 `mem_busy` high for 300 cycles -> `mem_timeout` rises on cycle 255 and stays set after `mem_busy` drops; `rst` clears it.
REQ-046 Preload `stall_cnt` near saturation and hold a hazard -> the counter sticks at 16'hFFFF. Assert `rst` mid-MEM_WAIT -> `state` = 0 and all counters = 0 immediately.
